// File: rtl/datapath_xyz_if.sv
// Command/status bundle for datapath_xyz: command fields in, register views and status out.
// The master side issues commands; the slave side is the datapath.
interface datapath_xyz_if #(
  parameter int unsigned N = 8
);
  logic         i_valid;
  logic [1:0]   i_tx;
  logic [1:0]   i_ty;
  logic [1:0]   i_tz;
  logic         i_tula;
  logic [N-1:0] i_entrada;
  logic [N-1:0] o_saida;
  logic [N-1:0] o_reg_x;
  logic [N-1:0] o_reg_y;
  logic         o_carry;
  logic         o_done;

  modport master (
    output i_valid, i_tx, i_ty, i_tz, i_tula, i_entrada,
    input  o_saida, o_reg_x, o_reg_y, o_carry, o_done
  );

  modport slave (
    input  i_valid, i_tx, i_ty, i_tz, i_tula, i_entrada,
    output o_saida, o_reg_x, o_reg_y, o_carry, o_done
  );
endinterface

// File: rtl/datapath_xyz.sv
// Three-register (X/Y/Z) datapath with an add/subtract ALU feeding Y.
// One command per Valid edge; Done acknowledges it one cycle later.
module datapath_xyz #(
  parameter int unsigned N = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  datapath_xyz_if.slave bus
);

  localparam logic [1:0] CodeHold  = 2'b00;
  localparam logic [1:0] CodeLoad  = 2'b01;
  localparam logic [1:0] CodeShift = 2'b10;
  localparam logic [1:0] CodeClear = 2'b11;

  logic [N-1:0] r_x, r_y, r_z;
  logic         r_carry;
  logic         r_done;

  logic [N:0]   w_alu;
  logic [N-1:0] w_x_d, w_y_d, w_z_d;
  logic         w_carry_d;

  function automatic logic [N-1:0] f_next(input logic [1:0]   code,
                                          input logic [N-1:0] cur,
                                          input logic [N-1:0] src);
    logic [N-1:0] res;
    res = cur;
    case (code)
      CodeHold:  res = cur;
      CodeLoad:  res = src;
      CodeShift: res = cur >> 1;
      CodeClear: res = '0;
      default:   res = cur;
    endcase
    return res;
  endfunction

  // Bit N is carry-out for add and borrow (X > Y) for subtract.
  always_comb begin
    if (bus.i_tula) begin
      w_alu = {1'b0, r_y} - {1'b0, r_x};
    end else begin
      w_alu = {1'b0, r_x} + {1'b0, r_y};
    end
  end

  always_comb begin
    w_x_d     = f_next(bus.i_tx, r_x, bus.i_entrada);
    w_y_d     = f_next(bus.i_ty, r_y, w_alu[N-1:0]);
    w_z_d     = f_next(bus.i_tz, r_z, r_y);
    w_carry_d = r_carry;
    if (bus.i_ty == CodeLoad) begin
      w_carry_d = w_alu[N];
    end else if (bus.i_ty == CodeClear) begin
      w_carry_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_carry <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= bus.i_valid;
      if (bus.i_valid) begin
        r_x     <= w_x_d;
        r_y     <= w_y_d;
        r_z     <= w_z_d;
        r_carry <= w_carry_d;
      end
    end
  end

  assign bus.o_saida = r_z;
  assign bus.o_reg_x = r_x;
  assign bus.o_reg_y = r_y;
  assign bus.o_carry = r_carry;
  assign bus.o_done  = r_done;

endmodule
